// File: rtl/shift_sequencer.sv
// Command sequencer that expands LOAD / SHR / SHL / ROTR commands into per-cycle
// mode and serial-input drive for a downstream multifunction shift register.
module shift_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [2:0]       cmd_steps,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       reg_s,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_shr_in,
  output logic             reg_shl_in,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             fill_reg, fill_next;
  logic [2:0]       count_reg, count_next;

  logic             accept;
  logic             exec_active;
  logic             load_active;

  // Only the LSB of the register feeds back (rotate-right wraps it into the MSB).
  logic             unused_reg_q_bits;
  assign unused_reg_q_bits = &{1'b0, reg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_LOAD;
      data_reg  <= '0;
      fill_reg  <= 1'b0;
      count_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      fill_reg  <= fill_next;
      count_reg <= count_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    fill_next  = fill_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next   = cmd_op;
          data_next = cmd_data;
          fill_next = cmd_fill;
          if (cmd_op == OP_LOAD) begin
            count_next = 3'd1;
            state_next = EXEC;
          end else if (cmd_steps == 3'd0) begin
            count_next = 3'd0;
            state_next = DONE;
          end else begin
            count_next = cmd_steps;
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        count_next = count_reg - 3'd1;
        // Treat a zero count as terminal too so a corrupted counter cannot stall EXEC.
        if (count_reg <= 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign exec_active = (state_reg == EXEC);
  assign load_active = exec_active && (op_reg == OP_LOAD);
  assign busy        = (state_reg == EXEC) || (state_reg == DONE);
  assign done        = (state_reg == DONE);

  always_comb begin
    reg_s      = MODE_HOLD;
    reg_shr_in = 1'b0;
    reg_shl_in = 1'b0;
    if (exec_active) begin
      case (op_reg)
        OP_LOAD: reg_s = MODE_LOAD;
        OP_SHR: begin
          reg_s      = MODE_SHR;
          reg_shr_in = fill_reg;
        end
        OP_SHL: begin
          reg_s      = MODE_SHL;
          reg_shl_in = fill_reg;
        end
        OP_ROTR: begin
          reg_s      = MODE_SHR;
          reg_shr_in = reg_q[0];
        end
        default: reg_s = MODE_HOLD;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_load_data
      assign reg_d[gi] = load_active & data_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: a behavioural shift register sits downstream of the sequencer
// and every command is checked cycle by cycle against an arithmetic reference.
module tb_shift_sequencer;

  localparam int W = 4;
  localparam logic [1:0] LOAD = 2'b00, SHR = 2'b01, SHL = 2'b10, ROTR = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [2:0]   cmd_steps = 3'd0;
  logic         cmd_fill = 1'b0;
  logic [W-1:0] reg_q;
  logic [1:0]   reg_s;
  logic [W-1:0] reg_d;
  logic         reg_shr_in, reg_shl_in, busy, done;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  int done_cnt = 0;
  logic [W-1:0] q_reg = '0;
  logic [W-1:0] ref_q = '0;

  shift_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps), .cmd_fill(cmd_fill),
    .reg_q(reg_q), .reg_s(reg_s), .reg_d(reg_d), .reg_shr_in(reg_shr_in),
    .reg_shl_in(reg_shl_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream register, not reset by the sequencer reset.
  assign reg_q = q_reg;
  always @(posedge clk) begin
    case (reg_s)
      2'b01:   q_reg <= reg_d;
      2'b10:   q_reg <= {reg_shr_in, q_reg[W-1:1]};
      2'b11:   q_reg <= {q_reg[W-2:0], reg_shl_in};
      default: q_reg <= q_reg;
    endcase
  end

  always @(posedge clk) begin
    if (reset && cmd_valid && cmd_ready) accept_cnt <= accept_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {reg_s, reg_d, shr_in, shl_in, busy, done, cmd_ready}
  function automatic logic [31:0] outs();
    return 32'({reg_s, reg_d, reg_shr_in, reg_shl_in, busy, done, cmd_ready});
  endfunction

  function automatic logic [31:0] vec(input logic [1:0] s, input logic [W-1:0] d,
                                      input logic shr, input logic shl, input logic b,
                                      input logic dn, input logic rdy);
    return 32'({s, d, shr, shl, b, dn, rdy});
  endfunction

  // Arithmetic view of one register operation.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] q, input logic [1:0] op,
                                            input logic [W-1:0] data, input logic fill);
    int v, m;
    m = (1 << W) - 1;
    v = int'(q);
    case (op)
      LOAD:    v = int'(data);
      SHR:     v = (v >> 1) + (int'(fill) << (W - 1));
      SHL:     v = ((v << 1) + int'(fill)) & m;
      default: v = (v >> 1) + ((v % 2) << (W - 1));
    endcase
    return W'(v);
  endfunction

  task automatic present(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [2:0] steps, input logic fill);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    cmd_fill  = fill;
  endtask

  // Called at a negedge with the command already presented. Optionally presents the
  // next command immediately after acceptance so it is held through busy.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [2:0] steps, input logic fill, input bit chain,
                         input logic [1:0] nop, input logic [W-1:0] ndata,
                         input logic [2:0] nsteps, input logic nfill);
    int waited, n, a0, d0;
    logic [1:0] es;
    logic       eshr;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 32'(waited < 20), 32'd1);
    a0 = accept_cnt;
    d0 = done_cnt;
    @(posedge clk);
    n = (op == LOAD) ? 1 : int'(steps);
    @(negedge clk);
    if (chain) present(nop, ndata, nsteps, nfill);
    else begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = W'($urandom);
      cmd_steps = 3'($urandom);
      cmd_fill  = 1'($urandom);
    end
    for (int i = 0; i < n; i++) begin
      es   = (op == LOAD) ? 2'b01 : (op == SHL) ? 2'b11 : 2'b10;
      eshr = (op == SHR) ? fill : (op == ROTR) ? ref_q[0] : 1'b0;
      check("exec_outs", outs(), vec(es, (op == LOAD) ? data : '0, eshr,
                                     (op == SHL) ? fill : 1'b0, 1'b1, 1'b0, 1'b0));
      ref_q = ref_step(ref_q, op, data, fill);
      @(posedge clk);
      @(negedge clk);
    end
    check("done_outs", outs(), vec(2'b00, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    check("reg_value", 32'(q_reg), 32'(ref_q));
    @(posedge clk);
    @(negedge clk);
    check("idle_outs", outs(), vec(2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check("accepts", 32'(accept_cnt - a0), 32'd1);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    $display("cmd op=%0d data=%h steps=%0d fill=%0b -> q=%h (expected %h)",
             op, data, steps, fill, q_reg, ref_q);
  endtask

  task automatic run_one(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [2:0] steps, input logic fill);
    present(op, data, steps, fill);
    run_cmd(op, data, steps, fill, 1'b0, 2'b00, '0, 3'd0, 1'b0);
  endtask

  initial begin
    logic [1:0]   op, nop;
    logic [W-1:0] data, ndata;
    logic [2:0]   steps, nsteps;
    logic         fill, nfill;
    bit           chain, pending;
    int           a0, d0;

    #1;
    check("reset_outs", outs(), vec(2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    present(LOAD, 4'hF, 3'd3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("no_accept_in_reset", outs(), vec(2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check("no_accept_cnt", 32'(accept_cnt), 32'd0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_one(LOAD, 4'b1010, 3'd0, 1'b0);
    run_one(SHR, 4'h0, 3'd3, 1'b1);
    run_one(LOAD, 4'b0011, 3'd0, 1'b0);
    run_one(SHL, 4'h0, 3'd2, 1'b0);
    run_one(LOAD, 4'b1001, 3'd0, 1'b0);
    run_one(ROTR, 4'h0, 3'd4, 1'b0);
    run_one(SHR, 4'h0, 3'd0, 1'b1);
    run_one(SHL, 4'h0, 3'd7, 1'b1);

    // Second command held valid through busy
    present(SHR, 4'h0, 3'd1, 1'b0);
    run_cmd(SHR, 4'h0, 3'd1, 1'b0, 1'b1, LOAD, 4'b0101, 3'd6, 1'b1);
    run_cmd(LOAD, 4'b0101, 3'd6, 1'b1, 1'b0, 2'b00, '0, 3'd0, 1'b0);

    // Reset in the middle of a 5-step SHL
    a0 = accept_cnt;
    d0 = done_cnt;
    present(SHL, 4'h0, 3'd5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", outs(), vec(2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    ref_q = ref_step(ref_step(ref_q, SHL, '0, 1'b1), SHL, '0, 1'b1);
    @(negedge clk);
    present(LOAD, 4'b0110, 3'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("reset_keeps_reg", 32'(q_reg), 32'(ref_q));
    check("reset_no_accept", 32'(accept_cnt - a0), 32'd1);
    check("reset_no_done", 32'(done_cnt - d0), 32'd0);
    reset = 1'b1;
    run_cmd(LOAD, 4'b0110, 3'd0, 1'b0, 1'b0, 2'b00, '0, 3'd0, 1'b0);

    // Randomized commands, some chained back-to-back through busy
    pending = 1'b0;
    op = LOAD; data = '0; steps = '0; fill = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!pending) begin
        op    = 2'($urandom);
        data  = W'($urandom);
        steps = 3'($urandom);
        fill  = 1'($urandom);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
        present(op, data, steps, fill);
      end
      chain  = ($urandom_range(0, 2) == 0);
      nop    = 2'($urandom);
      ndata  = W'($urandom);
      nsteps = 3'($urandom);
      nfill  = 1'($urandom);
      run_cmd(op, data, steps, fill, chain && (k < 39), nop, ndata, nsteps, nfill);
      pending = chain && (k < 39);
      if (pending) begin
        op = nop; data = ndata; steps = nsteps; fill = nfill;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
